// File: rtl/shift_sequencer.sv
// Multi-cycle ARM operand-2 shifter: decodes Src2, resolves the shift amount and
// applies it STEP bits per cycle, with a start/busy/done handshake.
module shift_sequencer #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] RD2,
  input  logic [31:0] Rs,
  input  logic [11:0] Src2,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] Shifted,
  output logic        carry_out
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [5:0] StepW = 6'(STEP);

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic        carry_q, carry_d;
  logic [1:0]  type_q, type_d;
  logic        rrx_q, rrx_d;
  logic [5:0]  remain_q, remain_d;

  logic [4:0]  shamt;
  logic [7:0]  amt;
  logic [1:0]  ty;
  logic [5:0]  n_c;
  logic        rrx_c;
  logic [5:0]  m_c;
  logic [31:0] step_w;
  logic        step_c;
  logic        unused_bits;

  assign shamt       = Src2[11:7];
  assign ty          = Src2[6:5];
  assign amt         = Rs[7:0];
  assign unused_bits = ^{Rs[31:8], Src2[3:0]};

  // Effective amount N; RRX is carried as a one-step special case.
  always_comb begin
    n_c   = '0;
    rrx_c = 1'b0;
    if (!Src2[4]) begin
      unique case (ty)
        2'b00:        n_c = {1'b0, shamt};
        2'b01, 2'b10: n_c = (shamt == 5'd0) ? 6'd32 : {1'b0, shamt};
        default: begin
          if (shamt == 5'd0) begin
            rrx_c = 1'b1;
            n_c   = 6'd1;
          end else begin
            n_c = {1'b0, shamt};
          end
        end
      endcase
    end else if (amt != 8'd0) begin
      unique case (ty)
        2'b00, 2'b01: n_c = (amt > 8'd33) ? 6'd33 : amt[5:0];
        2'b10:        n_c = (amt > 8'd32) ? 6'd32 : amt[5:0];
        default:      n_c = (amt[4:0] == 5'd0) ? 6'd32 : {1'b0, amt[4:0]};
      endcase
    end
  end

  // One SHIFT cycle: m single-bit steps, carry tracks the last bit out.
  always_comb begin
    m_c    = (remain_q < StepW) ? remain_q : StepW;
    step_w = work_q;
    step_c = carry_q;
    if (rrx_q) begin
      step_w = {carry_q, work_q[31:1]};
      step_c = work_q[0];
    end else begin
      for (int unsigned i = 0; i < STEP; i++) begin
        if (6'(i) < m_c) begin
          unique case (type_q)
            2'b00: begin step_c = step_w[31]; step_w = {step_w[30:0], 1'b0};       end
            2'b01: begin step_c = step_w[0];  step_w = {1'b0, step_w[31:1]};       end
            2'b10: begin step_c = step_w[0];  step_w = {step_w[31], step_w[31:1]}; end
            default: begin step_c = step_w[0]; step_w = {step_w[0], step_w[31:1]}; end
          endcase
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    carry_d  = carry_q;
    type_d   = type_q;
    rrx_d    = rrx_q;
    remain_d = remain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d   = RD2;
          carry_d  = carry_in;
          type_d   = ty;
          rrx_d    = rrx_c;
          remain_d = n_c;
          state_d  = (n_c == 6'd0) ? StDone : StShift;
        end
      end
      StShift: begin
        work_d   = step_w;
        carry_d  = step_c;
        remain_d = remain_q - m_c;
        if (remain_q == m_c) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      work_q   <= '0;
      carry_q  <= 1'b0;
      type_q   <= 2'b00;
      rrx_q    <= 1'b0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      carry_q  <= carry_d;
      type_q   <= type_d;
      rrx_q    <= rrx_d;
      remain_q <= remain_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign Shifted   = work_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected results, a monitor
// pops and checks them (value, carry, done cycle) whenever done is seen.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] RD2;
  logic [31:0] Rs;
  logic [11:0] Src2;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] Shifted;
  logic        carry_out;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_chk;
  int   n_fail;

  shift_sequencer #(.STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .RD2       (RD2),
    .Rs        (Rs),
    .Src2      (Src2),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .Shifted   (Shifted),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, Shifted, e.res);
        chk({e.name, "_carry"}, {31'b0, carry_out}, {31'b0, e.c});
        chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One-cycle start pulse; k is the expected number of SHIFT cycles.
  task automatic issue(input string nm, input logic [11:0] s2, input logic [31:0] rd2,
                       input logic [31:0] rs, input logic cin, input logic [31:0] res,
                       input logic c, input int k, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1; Src2 = s2; RD2 = rd2; Rs = rs; carry_in = cin;
    if (push) begin
      e.name = nm; e.res = res; e.c = c; e.cyc = cyc + k + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    i = 0;
    while ((sb.size() != 0 || busy) && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (i >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d, expected idle", nm, busy, sb.size());
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0;
    RD2 = '0; Rs = '0; Src2 = '0; carry_in = 1'b0;
    cyc = 0; n_chk = 0; n_fail = 0;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_shifted", Shifted, 32'd0);
    chk("reset_carry", {31'b0, carry_out}, 32'd0);
    #12 rst_n = 1'b1;

    // Asynchronous reset in the middle of a 33-bit register LSR.
    issue("rst_mid", 12'h030, 32'h000ABCDE, 32'h00000021, 1'b1, '0, 1'b0, 9, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_shifted", Shifted, 32'd0);
    chk("midrst_carry", {31'b0, carry_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    issue("imm_lsr2", 12'h123, 32'h000ABCDE, 32'h0, 1'b0, 32'h0002AF37, 1'b1, 1, 1'b1);
    wait_idle("imm_lsr2");

    issue("imm_asr32", 12'h040, 32'h80000000, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1, 8, 1'b1);
    wait_idle("imm_asr32");

    // Register LSR by 33, with a start pulse during SHIFT that must be ignored.
    issue("reg_lsr33", 12'h030, 32'h000ABCDE, 32'h00054321, 1'b1, 32'h0, 1'b0, 9, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; Src2 = 12'h010; Rs = 32'h0; RD2 = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("reg_lsr33");
    repeat (3) @(posedge clk);

    issue("rrx", 12'h060, 32'h00000001, 32'h0, 1'b1, 32'h80000000, 1'b1, 1, 1'b1);
    wait_idle("rrx");

    issue("reg_lsl32", 12'h010, 32'h00000001, 32'h00000020, 1'b0, 32'h0, 1'b1, 8, 1'b1);
    wait_idle("reg_lsl32");

    issue("reg_ror32", 12'h070, 32'h80000001, 32'h00000020, 1'b0, 32'h80000001, 1'b1, 8, 1'b1);
    wait_idle("reg_ror32");

    // Zero amount then a start in the cycle right after DONE.
    issue("reg_lsl0", 12'h010, 32'h12345678, 32'h00000F00, 1'b1, 32'h12345678, 1'b1, 0, 1'b1);
    issue("b2b_lsl4", 12'h200, 32'h12345678, 32'h0, 1'b0, 32'h23456780, 1'b1, 1, 1'b1);
    wait_idle("b2b_lsl4");

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
